// File: rtl/ibis_dvi_scanout.sv
// Framebuffer scan-out: prefetches pixel bursts into a FIFO and feeds one pixel per de cycle to the TMDS encoders.
// Optional IBIS_SCANOUT_REPEAT_EN: on underflow, repeat the last popped pixel instead of black.
module ibis_dvi_scanout #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned BURST      = 16,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned ADDR_W     = 24
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          enable,
   input  logic [ADDR_W-1:0]             fb_base,
   input  logic                          frame_start,
   input  logic                          de,
   output logic                          req_valid,
   output logic [ADDR_W-1:0]             req_addr,
   input  logic                          req_ready,
   input  logic                          rsp_valid,
   input  logic [23:0]                   rsp_data,
   output logic [23:0]                   rgb,
   output logic                          underflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned PIX_W = 24;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned SUM_W = LVL_W + 2;
   localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);

   typedef enum logic [2:0] {IDLE, FLUSH, FETCH, REQ, DONE} state_t;

   state_t             state, state_nxt;
   logic               pend, pend_nxt;
   logic               req_valid_nxt;
   logic               hs_c, load_c;
   logic [LVL_W-1:0]   outstanding;
   logic [CNT_W-1:0]   fetch_cnt;
   logic [SUM_W-1:0]   used_c;
   logic               credit_ok_c, fetch_done_c;
   logic               flush_c, pop_c, push_c, rsp_dec_c;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [PIX_W-1:0]   mem [FIFO_DEPTH];

   // Room for another burst once buffered plus in-flight pixels leave BURST free.
   assign used_c       = SUM_W'(fifo_level) + SUM_W'(outstanding) + SUM_W'(BURST);
   assign credit_ok_c  = used_c <= SUM_W'(FIFO_DEPTH);
   assign fetch_done_c = fetch_cnt >= CNT_W'(TOTAL);

   assign flush_c   = (state == FLUSH);
   assign pop_c     = de && !flush_c && (fifo_level != '0);
   assign push_c    = rsp_valid && !flush_c && ((fifo_level != LVL_W'(FIFO_DEPTH)) || pop_c);
   assign rsp_dec_c = rsp_valid && (outstanding != '0);

   // Next-state logic; a frame restart seen during REQ waits for the handshake.
   always_comb begin
      state_nxt     = state;
      pend_nxt      = pend;
      req_valid_nxt = req_valid;
      hs_c          = 1'b0;
      load_c        = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) state_nxt = FLUSH;
         end
         FLUSH: begin
            if (!frame_start && (outstanding == '0)) begin
               load_c    = 1'b1;
               state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (frame_start) begin
               state_nxt = FLUSH;
            end else if (fetch_done_c) begin
               state_nxt = DONE;
            end else if (credit_ok_c) begin
               req_valid_nxt = 1'b1;
               state_nxt     = REQ;
            end
         end
         REQ: begin
            pend_nxt = pend || frame_start;
            if (req_ready) begin
               hs_c          = 1'b1;
               req_valid_nxt = 1'b0;
               pend_nxt      = 1'b0;
               state_nxt     = (pend || frame_start) ? FLUSH : FETCH;
            end
         end
         DONE: begin
            if (frame_start) state_nxt = FLUSH;
         end
         default: begin
            state_nxt     = IDLE;
            req_valid_nxt = 1'b0;
            pend_nxt      = 1'b0;
         end
      endcase
   end

   // Control registers: FSM state, request channel, credit counters.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state       <= IDLE;
         pend        <= 1'b0;
         req_valid   <= 1'b0;
         req_addr    <= '0;
         fetch_cnt   <= '0;
         outstanding <= '0;
      end else if (enable) begin
         state     <= state_nxt;
         pend      <= pend_nxt;
         req_valid <= req_valid_nxt;
         if (load_c) begin
            req_addr  <= fb_base;
            fetch_cnt <= '0;
         end else if (hs_c) begin
            req_addr  <= req_addr + ADDR_W'(BURST);
            fetch_cnt <= fetch_cnt + CNT_W'(BURST);
         end
         case ({hs_c, rsp_dec_c})
            2'b10:   outstanding <= outstanding + LVL_W'(BURST);
            2'b01:   outstanding <= outstanding - LVL_W'(1);
            2'b11:   outstanding <= outstanding + LVL_W'(BURST - 1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Pixel FIFO pointers, occupancy and output pixel.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         rgb        <= '0;
         underflow  <= 1'b0;
      end else if (enable) begin
         if (flush_c) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
         end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && !pop_c)      fifo_level <= fifo_level + LVL_W'(1);
            else if (pop_c && !push_c) fifo_level <= fifo_level - LVL_W'(1);
         end
         if (de) begin
            if (pop_c) begin
               rgb <= mem[rd_ptr];
            end else begin
               underflow <= 1'b1;
`ifdef IBIS_SCANOUT_REPEAT_EN
               // rgb only ever changes on a pop here, so it already holds the last popped pixel.
               rgb <= rgb;
`else
               rgb <= '0;
`endif
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (aresetn && enable && push_c) mem[wr_ptr] <= rsp_data;
   end

endmodule

// File: tb/tb_ibis_dvi_scanout.sv
// Directed self-checking bench for ibis_dvi_scanout on a reduced 32x4 raster with a 4-cycle-latency fabric model.
module tb_ibis_dvi_scanout;

   localparam int unsigned HA = 32;
   localparam int unsigned VA = 4;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b1;
   logic [23:0] fb_base = '0;
   logic        frame_start = 1'b0;
   logic        de = 1'b0;
   logic        req_valid;
   logic [23:0] req_addr;
   logic        req_ready = 1'b0;
   logic        rsp_valid = 1'b0;
   logic [23:0] rsp_data = '0;
   logic [23:0] rgb;
   logic        underflow;
   logic [6:0]  fifo_level;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int hs_cnt = 0;
   int rsp_k = 0;
   bit starve = 1'b0;
   int rsp_q[$];
   logic [23:0] hs_q[$];

   ibis_dvi_scanout #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BURST(16), .FIFO_DEPTH(64), .ADDR_W(24)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .fb_base(fb_base),
      .frame_start(frame_start), .de(de), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rgb(rgb),
      .underflow(underflow), .fifo_level(fifo_level));

   always #5 aclk = ~aclk;

   // Fabric: log accepted requests, schedule 16 responses starting 4 cycles later.
   always @(posedge aclk) begin
      if (aresetn && enable && req_valid && req_ready) begin
         hs_q.push_back(req_addr);
         hs_cnt++;
         for (int i = 0; i < 16; i++) rsp_q.push_back(cyc + 4 + i);
      end
      cyc++;
   end

   always @(negedge aclk) begin
      #1;
      if (!aresetn) begin
         rsp_q.delete();
         rsp_valid = 1'b0;
      end else if (!starve && enable && rsp_q.size() > 0 && rsp_q[0] <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = 24'hA00000 | 24'(rsp_k);
         rsp_k++;
         void'(rsp_q.pop_front());
      end else begin
         rsp_valid = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge aclk);
   endtask

   function automatic logic [23:0] pix(input int k);
      return 24'hA00000 | 24'(k);
   endfunction

   initial begin
      int k;
      // Test 1: reset values, first requests, credit-limited prefetch.
      repeat (2) tick();
      chk("rst_req_valid", 32'(req_valid), 0);
      chk("rst_req_addr", 32'(req_addr), 0);
      chk("rst_rgb", 32'(rgb), 0);
      chk("rst_underflow", 32'(underflow), 0);
      chk("rst_fifo_level", 32'(fifo_level), 0);
      aresetn = 1'b1;
      fb_base = 24'h001000;
      req_ready = 1'b1;
      tick();
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int n = 0; n < 300 && fifo_level != 7'd64; n++) tick();
      repeat (10) tick();
      chk("t1_level_full", 32'(fifo_level), 64);
      chk("t1_hs_count", 32'(hs_cnt), 4);
      chk("t1_req_paused", 32'(req_valid), 0);
      chk("t1_addr0", 32'(hs_q[0]), 32'h001000);
      chk("t1_addr1", 32'(hs_q[1]), 32'h001010);

      // Test 2: whole reduced frame, rgb follows de by one cycle in fetch order.
      k = 0;
      for (int ln = 0; ln < VA; ln++) begin
         for (int p = 0; p < HA; p++) begin
            de = 1'b1; tick();
            chk("t2_pixel", 32'(rgb), 32'(pix(k)));
            k++;
         end
         de = 1'b0;
         repeat (24) tick();
      end
      repeat (40) tick();
      chk("t2_hs_total", 32'(hs_cnt), 8);
      chk("t2_done_no_req", 32'(req_valid), 0);
      chk("t2_level_empty", 32'(fifo_level), 0);
      chk("t2_no_underflow", 32'(underflow), 0);

      // Test 3: frame restart while a request is stalled.
      req_ready = 1'b0;
      fb_base = 24'h000300;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
      for (int n = 0; n < 50 && !req_valid; n++) tick();
      chk("t3_req_addr", 32'(req_addr), 32'h000300);
      fb_base = 24'hFFFFF8;
      for (int i = 0; i < 10; i++) begin
         frame_start = (i == 0);
         tick();
         chk("t3_hold", {7'd0, req_valid, req_addr}, {7'd0, 1'b1, 24'h000300});
      end
      frame_start = 1'b0;
      chk("t3_no_hs_yet", 32'(hs_cnt), 8);
      req_ready = 1'b1;
      tick();
      for (int n = 0; n < 300 && fifo_level != 7'd64; n++) tick();
      repeat (10) tick();
      chk("t3_level_full", 32'(fifo_level), 64);
      chk("t3_hs_count", 32'(hs_cnt), 13);
      chk("t3_stalled_addr", 32'(hs_q[8]), 32'h000300);
      chk("t3_reload_addr", 32'(hs_q[9]), 32'hFFFFF8);
      chk("t3_wrap_addr", 32'(hs_q[10]), 32'h000008);

      // Test 4: drain the FIFO (flushed data skipped), then underflow.
      req_ready = 1'b0;
      for (int j = 0; j < 64; j++) begin
         de = 1'b1; tick();
         chk("t4_pixel", 32'(rgb), 32'(pix(144 + j)));
      end
      chk("t4_level_empty", 32'(fifo_level), 0);
      chk("t4_no_underflow_yet", 32'(underflow), 0);
      tick();
`ifdef IBIS_SCANOUT_REPEAT_EN
      chk("t4_underflow_rgb", 32'(rgb), 32'(pix(207)));
`else
      chk("t4_underflow_rgb", 32'(rgb), 0);
`endif
      chk("t4_underflow_set", 32'(underflow), 1);
      de = 1'b0;
      repeat (3) tick();
      chk("t4_underflow_sticky", 32'(underflow), 1);

      // Test 5: clock-enable freeze with de high.
      chk("t5_req_valid", 32'(req_valid), 1);
      chk("t5_req_addr", 32'(req_addr), 32'h000038);
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      repeat (30) tick();
      chk("t5_level", 32'(fifo_level), 16);
      chk("t5_next_addr", 32'(req_addr), 32'h000048);
      for (int j = 0; j < 3; j++) begin
         de = 1'b1; tick();
         chk("t5_pixel", 32'(rgb), 32'(pix(208 + j)));
      end
      enable = 1'b0;
      for (int j = 0; j < 5; j++) begin
         tick();
         chk("t5_frz_level", 32'(fifo_level), 13);
         chk("t5_frz_rgb", 32'(rgb), 32'(pix(210)));
         chk("t5_frz_req", {7'd0, req_valid, req_addr}, {7'd0, 1'b1, 24'h000048});
      end
      enable = 1'b1;
      tick();
      chk("t5_resume_rgb", 32'(rgb), 32'(pix(211)));
      chk("t5_resume_level", 32'(fifo_level), 12);
      de = 1'b0;
      chk("t5_underflow_sticky", 32'(underflow), 1);

      // Test 6: reset while stalled in REQ with 32 pixels in flight.
      starve = 1'b1;
      req_ready = 1'b1;
      for (int n = 0; n < 20 && hs_cnt < 16; n++) tick();
      req_ready = 1'b0;
      chk("t6_hs_count", 32'(hs_cnt), 16);
      repeat (3) tick();
      chk("t6_in_req", {7'd0, req_valid, req_addr}, {7'd0, 1'b1, 24'h000068});
      aresetn = 1'b0;
      tick();
      chk("t6_rst_req_valid", 32'(req_valid), 0);
      chk("t6_rst_level", 32'(fifo_level), 0);
      chk("t6_rst_rgb", 32'(rgb), 0);
      chk("t6_rst_underflow", 32'(underflow), 0);
      chk("t6_rst_addr", 32'(req_addr), 0);
      aresetn = 1'b1;
      starve = 1'b0;
      req_ready = 1'b1;
      repeat (20) tick();
      chk("t6_idle_no_req", 32'(req_valid), 0);
      chk("t6_idle_no_hs", 32'(hs_cnt), 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ibis_dvi_scanout.md
Name: ibis_dvi_scanout

Overview:
Framebuffer scan-out controller between the memory fabric and the three TMDS pixel encoders. Issues burst read requests ahead of the raster and buffers returned pixels in an internal FIFO. Pops one pixel per active-video cycle from ibis_vga_timing onto the 24-bit RGB bus feeding the red, green and blue TMDS channels. Handles per-frame restart, back-pressure, and underflow reporting.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BURST, 16, pixels per read request (power of 2, <= FIFO_DEPTH/2)
FIFO_DEPTH, 64, pixel FIFO entries (power of 2)
ADDR_W, 24, pixel-granular address width

Ports:
aclk  in  1  sole clock (pixel clock domain)
aresetn  in  1  synchronous active-low reset
enable  in  1  clock enable; low = all state held, outputs frozen
fb_base  in  ADDR_W  frame base address, sampled on frame restart
frame_start  in  1  one-cycle pulse at start of vertical blank
de  in  1  active-video strobe; one pixel consumed per cycle
req_valid  out  1  read request valid
req_addr  out  ADDR_W  request start address
req_ready  in  1  fabric accepts request
rsp_valid  in  1  one returned pixel
rsp_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}
rgb  out  24  registered pixel to TMDS encoders
underflow  out  1  sticky: de with FIFO empty
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (aresetn low at posedge): state IDLE; req_valid=0, req_addr=0, rgb=0, underflow=0, fifo_level=0, outstanding=0, fetch count=0.
- All state updates are qualified by enable; with enable=0 nothing changes, including FIFO writes. Responses arriving while enable=0 are lost; the fabric must not return data then.
- FSM:
  - IDLE: wait for frame_start, then go to FLUSH.
  - FLUSH: discard all responses until outstanding==0. Clear FIFO. Load req_addr=fb_base and fetch count=0. Go to FETCH.
  - FETCH: if credit >= BURST and fetch count < H_ACTIVE*V_ACTIVE, assert req_valid and go to REQ. Credit = FIFO_DEPTH - fifo_level - outstanding.
  - REQ: hold req_valid and req_addr stable until req_ready. On handshake: outstanding += BURST, req_addr += BURST, fetch count += BURST, return to FETCH.
  - When fetch count reaches H_ACTIVE*V_ACTIVE, go to DONE. DONE holds until frame_start, then goes to FLUSH.
- frame_start in any state other than REQ: go to FLUSH next cycle. frame_start during REQ: latch as pending and act on it the cycle after the handshake. Never drop req_valid without req_ready.
- Response path:
  - Each rsp_valid decrements outstanding by 1. It writes the FIFO unless in FLUSH.
  - Credit accounting guarantees no overflow. A write to a full FIFO is dropped.
- Pixel path:
  - On de with FIFO non-empty: pop, and rgb <= head at the next edge (1-cycle latency de->rgb).
  - On de with FIFO empty: rgb <= 24'h000000 and underflow <= 1. underflow is cleared only by reset.
  - When de=0: rgb holds its last value.
- Simultaneous push and pop in one cycle: fifo_level unchanged. Data stays correct at both the full and empty boundaries.
- Address arithmetic wraps modulo 2^ADDR_W. Fetch count width is $clog2(H_ACTIVE*V_ACTIVE+1).
- A de pulse during FLUSH pops nothing and counts as underflow.

Optional Feature:
IBIS_SCANOUT_REPEAT_EN
- Defined: on underflow, rgb repeats the last successfully popped pixel instead of black. underflow is still set.
- Undefined: underflow drives rgb=24'h000000.

Test Plan:
1. Reset then frame_start, req_ready=1, 4-cycle response latency -> first req_addr=fb_base, next fb_base+16; requests pause once fifo_level+outstanding reaches 64; no overflow.
2. Full 640x480 frame with de per raster and incrementing rsp_data -> rgb equals data in order, 1 cycle after de; 19200 requests total; FSM ends in DONE; underflow=0.
3. req_ready held low 10 cycles while frame_start pulses -> req_valid and req_addr stable until handshake; FLUSH follows; next request uses fb_base reloaded.
4. Starve responses, assert de with FIFO empty -> rgb=0 (or last pixel with IBIS_SCANOUT_REPEAT_EN); underflow=1 and stays 1 until aresetn low.
5. enable=0 for 5 cycles mid-burst with de high -> fifo_level, rgb, req_* unchanged; resumes exactly on enable=1.
6. aresetn low mid-REQ with outstanding=32 -> next cycle req_valid=0, fifo_level=0, rgb=0, state IDLE.
